// File: rtl/control_unit.sv
// Moore sequencer for the ProjectB datapath: fetches into an internal IR and decodes it into
// PC, data-memory, register-file and ALU controls. All outputs come straight from flops.
module control_unit #(
  parameter int IR_W    = 16,
  parameter int DADDR_W = 8,
  parameter int RFA_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IR_W-1:0]    instr_in,
  output logic               pc_clr,
  output logic               pc_up,
  output logic [IR_W-1:0]    ir_out,
  output logic [DADDR_W-1:0] d_addr,
  output logic               d_wr,
  output logic               rf_s,
  output logic [RFA_W-1:0]   rf_w_addr,
  output logic               rf_w_en,
  output logic [RFA_W-1:0]   rf_ra_addr,
  output logic [RFA_W-1:0]   rf_rb_addr,
  output logic [2:0]         alu_s0,
  output logic [3:0]         out_state
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [3:0]          opcode;
  logic                pc_clr_d, pc_up_d, d_wr_d, rf_s_d, rf_w_en_d;
  logic [DADDR_W-1:0]  d_addr_d, mem_addr;
  logic [RFA_W-1:0]    rf_w_addr_d, rf_ra_addr_d, rf_rb_addr_d;
  logic [RFA_W-1:0]    fld_ra, fld_rb, fld_rd;
  logic [2:0]          alu_s0_d;

  assign opcode = ir_q[IR_W-1 -: 4];

  always_comb begin
    state_d = S_INIT;
    ir_d    = ir_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_DECODE;
        ir_d    = instr_in;
      end
      S_DECODE: begin
        case (opcode)
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_LOAD_A;
          4'h3:    state_d = S_ADD;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_HALT;
          default: state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Outputs are decoded from the *next* state/IR so the registered copies line up with state_q.
  assign mem_addr = ir_d[DADDR_W+RFA_W-1:RFA_W];
  assign fld_ra   = ir_d[3*RFA_W-1 -: RFA_W];
  assign fld_rb   = ir_d[2*RFA_W-1 -: RFA_W];
  assign fld_rd   = ir_d[RFA_W-1:0];

  always_comb begin
    pc_clr_d     = 1'b0;
    pc_up_d      = 1'b0;
    d_addr_d     = '0;
    d_wr_d       = 1'b0;
    rf_s_d       = 1'b0;
    rf_w_addr_d  = '0;
    rf_w_en_d    = 1'b0;
    rf_ra_addr_d = '0;
    rf_rb_addr_d = '0;
    alu_s0_d     = 3'b000;
    case (state_d)
      S_INIT:   pc_clr_d = 1'b1;
      S_FETCH:  pc_up_d  = 1'b1;
      S_LOAD_A: d_addr_d = mem_addr;
      S_LOAD_B: begin
        d_addr_d    = mem_addr;
        rf_s_d      = 1'b1;
        rf_w_en_d   = 1'b1;
        rf_w_addr_d = fld_rd;
      end
      S_STORE: begin
        d_addr_d     = mem_addr;
        rf_ra_addr_d = fld_rd;
        d_wr_d       = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr_d = fld_ra;
        rf_rb_addr_d = fld_rb;
        rf_w_addr_d  = fld_rd;
        rf_w_en_d    = 1'b1;
        alu_s0_d     = (state_d == S_ADD) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      ir_q       <= '0;
      pc_clr     <= 1'b1;
      pc_up      <= 1'b0;
      d_addr     <= '0;
      d_wr       <= 1'b0;
      rf_s       <= 1'b0;
      rf_w_addr  <= '0;
      rf_w_en    <= 1'b0;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      alu_s0     <= 3'b000;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_clr     <= pc_clr_d;
      pc_up      <= pc_up_d;
      d_addr     <= d_addr_d;
      d_wr       <= d_wr_d;
      rf_s       <= rf_s_d;
      rf_w_addr  <= rf_w_addr_d;
      rf_w_en    <= rf_w_en_d;
      rf_ra_addr <= rf_ra_addr_d;
      rf_rb_addr <= rf_rb_addr_d;
      alu_s0     <= alu_s0_d;
    end
  end

  assign ir_out    = ir_q;
  assign out_state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural PC + instruction ROM feed the FSM, and each instruction
// is expanded into its expected per-cycle output trace from the opcode rules.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        pc_clr, pc_up, d_wr, rf_s, rf_w_en;
  logic [15:0] ir_out;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, out_state;
  logic [2:0]  alu_s0;

  control_unit dut (
    .clk(clk), .reset(reset), .instr_in(instr_in),
    .pc_clr(pc_clr), .pc_up(pc_up), .ir_out(ir_out),
    .d_addr(d_addr), .d_wr(d_wr), .rf_s(rf_s),
    .rf_w_addr(rf_w_addr), .rf_w_en(rf_w_en),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .alu_s0(alu_s0), .out_state(out_state)
  );

  always #5 clk = ~clk;

  // Behavioural PC_Counter (7-bit, wraps 127->0) and instruction ROM.
  bit [15:0] mem [128];
  bit [6:0]  pc = '0;
  always @(posedge clk) begin
    if (pc_clr)     pc <= '0;
    else if (pc_up) pc <= pc + 7'd1;
  end
  assign instr_in = mem[pc];

  logic [47:0] obs;
  assign obs = {pc_clr, pc_up, ir_out, d_addr, d_wr, rf_s, rf_w_addr,
                rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0, out_state};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  function automatic logic [47:0] snap(
    input bit clr, input bit up, input bit [15:0] ir, input bit [7:0] da,
    input bit wr, input bit s, input bit [3:0] wa, input bit wen,
    input bit [3:0] ra, input bit [3:0] rb, input bit [2:0] alu, input bit [3:0] st);
    return {clr, up, ir, da, wr, s, wa, wen, ra, rb, alu, st};
  endfunction

  logic [47:0] exp_q[$];
  string       tag_q[$];
  bit [15:0]   m_ir;
  bit [6:0]    m_pc;

  task automatic push(input string t, input logic [47:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  // Expected trace of one instruction, from FETCH entry until the next FETCH entry.
  task automatic queue_instr();
    bit [15:0] w;
    w = mem[m_pc];
    push("fetch",  snap(0, 1, m_ir, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    push("decode", snap(0, 0, w, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    case (w[15:12])
      4'h1: push("store", snap(0, 0, w, w[11:4], 1, 0, 0, 0, w[3:0], 0, 0, 6));
      4'h2: begin
        push("load_a", snap(0, 0, w, w[11:4], 0, 0, 0, 0, 0, 0, 0, 4));
        push("load_b", snap(0, 0, w, w[11:4], 0, 1, w[3:0], 1, 0, 0, 0, 5));
      end
      4'h3: push("add", snap(0, 0, w, 0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'b001, 7));
      4'h4: push("sub", snap(0, 0, w, 0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'b010, 8));
      4'h5: push("halt", snap(0, 0, w, 0, 0, 0, 0, 0, 0, 0, 0, 9));
      default: push("noop", snap(0, 0, w, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    endcase
    m_ir = w;
    m_pc = m_pc + 7'd1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge clk);
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Holds reset over a few edges, checks the INIT outputs, releases at a negedge.
  task automatic reset_and_start(input string t);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk(t, obs, snap(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    exp_q.delete();
    tag_q.delete();
    m_ir = '0;
    m_pc = '0;
  endtask

  initial begin
    bit [3:0] op;
    reset = 1'b1;
    mem[0] = 16'h2AB3;
    mem[1] = 16'h1AB3;
    mem[2] = 16'h3125;
    mem[3] = 16'h4125;
    mem[4] = 16'hF0C7;
    for (int i = 5; i < 128; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd5) op = op + 4'd1;
      mem[i] = {op, 12'($urandom)};
    end

    // Random stream past the 127->0 wrap; every cycle is compared.
    reset_and_start("reset");
    for (int i = 0; i < 140; i++) queue_instr();
    drain(1000);

    // Asynchronous reset in the middle of an ADD.
    mem[0] = 16'h3125;
    reset_and_start("reset2");
    queue_instr();
    drain(3);
    #1 reset = 1'b1;
    #1 chk("mid_add_reset", obs, snap(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("reset_hold", obs, snap(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    exp_q.delete();
    tag_q.delete();
    m_ir = '0;
    m_pc = '0;
    for (int i = 0; i < 5; i++) queue_instr();
    drain(100);

    // HALT sticks for 50 cycles with no strobes.
    mem[1] = 16'h5ABC;
    reset_and_start("reset3");
    queue_instr();
    queue_instr();
    for (int i = 0; i < 49; i++)
      push("halt_hold", snap(0, 0, 16'h5ABC, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
